// File: rtl/sbqm_pkg.sv
// sbqm_pkg: shared divider state type, numerator sizing and the "no service" wait constant.
package sbqm_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} divState;
  localparam logic [31:0] W_TIME_INF = '1;
  function automatic int numWidth(int depth, int tellerW, int svcTime);
    int w;
    w = $clog2(svcTime * (depth + 2 ** tellerW - 2) + 1);
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/sbqm_queue_ctrl_if.sv
// sbqm_queue_ctrl_if: sensor inputs and queue status outputs.
// peak_count/served_count exist only when QUEUE_STATS_EN is defined.
interface sbqm_queue_ctrl_if #(
  parameter int DEPTH = 7,
  parameter int TELLER_W = 2,
  parameter int WT_W = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic back_sensor, front_sensor, err_clr;
  logic [TELLER_W-1:0] t_count;
  logic [CNT_W-1:0] p_count;
  logic empty_flag, full_flag, wt_valid, ovf_err, udf_err;
  logic [WT_W-1:0] w_time;
`ifdef QUEUE_STATS_EN
  logic [CNT_W-1:0] peak_count;
  logic [15:0] served_count;
  modport master(output back_sensor, front_sensor, t_count, err_clr,
                 input p_count, empty_flag, full_flag, w_time, wt_valid, ovf_err, udf_err, peak_count, served_count);
  modport slave(input back_sensor, front_sensor, t_count, err_clr,
                output p_count, empty_flag, full_flag, w_time, wt_valid, ovf_err, udf_err, peak_count, served_count);
`else
  modport master(output back_sensor, front_sensor, t_count, err_clr,
                 input p_count, empty_flag, full_flag, w_time, wt_valid, ovf_err, udf_err);
  modport slave(input back_sensor, front_sensor, t_count, err_clr,
                output p_count, empty_flag, full_flag, w_time, wt_valid, ovf_err, udf_err);
`endif
endinterface

// File: rtl/sbqm_wait_div.sv
// sbqm_wait_div: unsigned restoring divider, one quotient bit per cycle; done pulses after NUM_W steps.
module sbqm_wait_div #(
  parameter int NUM_W = 5,
  parameter int TELLER_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_W-1:0]    num,
  input  logic [TELLER_W-1:0] den,
  output logic                done,
  output logic [NUM_W-1:0]    quot
);
  localparam int CW = $clog2(NUM_W + 1);
  logic [TELLER_W-1:0] rem;
  logic [CW-1:0] cnt;
  logic [TELLER_W:0] trial;
  logic ge;
  always_comb begin
    trial = {rem, quot[NUM_W-1]};
    ge = trial >= {1'b0, den};
  end
  // quot doubles as the dividend shift register; quotient bits enter from the bottom
  always_ff @(posedge clk) begin
    if (!reset || abort) begin
      rem <= '0;
      quot <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else if (start) begin
      rem <= '0;
      quot <= num;
      cnt <= CW'(NUM_W);
      done <= 1'b0;
    end else if (cnt != '0) begin
      rem <= TELLER_W'(ge ? trial - {1'b0, den} : trial);
      quot <= (quot << 1) | NUM_W'(ge);
      cnt <= cnt - 1'b1;
      done <= cnt == CW'(1);
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/sbqm_queue_ctrl.sv
// sbqm_queue_ctrl: beam-sensor queue counter with empty/full flags, sticky errors and wait estimate.
// Define QUEUE_STATS_EN to add peak_count and served_count outputs.
module sbqm_queue_ctrl
  import sbqm_pkg::*;
#(
  parameter int DEPTH = 7,
  parameter int TELLER_W = 2,
  parameter int SVC_TIME = 3,
  parameter int WT_W = 5,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic reset,
  sbqm_queue_ctrl_if.slave bus
);
  localparam int NUM_W = numWidth(DEPTH, TELLER_W, SVC_TIME);
  localparam int WT_MAX = 2 ** WT_W - 1;
  logic [1:0] backSync, frontSync;
  logic backPrev, frontPrev;
  logic entry, exitEv, grow, shrink, ovfEv, udfEv;
  logic [CNT_W-1:0] pNext, opP;
  logic [TELLER_W-1:0] opT;
  divState state;
  logic opDiff, special, divStart, divAbort, divDone;
  logic [NUM_W-1:0] num, quot;
  logic [WT_W-1:0] specialTime;
  always_comb begin
    entry = backPrev & ~backSync[1];
    exitEv = frontPrev & ~frontSync[1];
    grow = entry & ~exitEv;
    shrink = exitEv & ~entry;
    ovfEv = grow & (bus.p_count == CNT_W'(DEPTH));
    udfEv = shrink & (bus.p_count == '0);
    pNext = (grow & ~ovfEv) ? bus.p_count + 1'b1 : (shrink & ~udfEv) ? bus.p_count - 1'b1 : bus.p_count;
    // compare against next occupancy so wt_valid drops in the same cycle p_count moves
    opDiff = {pNext, bus.t_count} != {opP, opT};
    special = (opP == '0) | (opT == '0);
    specialTime = (opP == '0) ? '0 : WT_W'(W_TIME_INF);
    num = NUM_W'(SVC_TIME * (int'(opP) + int'(opT) - 1));
    divStart = (state == LOAD) & ~opDiff & ~special;
    divAbort = (state == CALC) & opDiff;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      backSync <= '0;
      frontSync <= '0;
      backPrev <= 1'b0;
      frontPrev <= 1'b0;
      bus.p_count <= '0;
      bus.empty_flag <= 1'b1;
      bus.full_flag <= 1'b0;
      bus.ovf_err <= 1'b0;
      bus.udf_err <= 1'b0;
    end else begin
      backSync <= {backSync[0], bus.back_sensor};
      frontSync <= {frontSync[0], bus.front_sensor};
      backPrev <= backSync[1];
      frontPrev <= frontSync[1];
      bus.p_count <= pNext;
      bus.empty_flag <= pNext == '0;
      bus.full_flag <= pNext == CNT_W'(DEPTH);
      bus.ovf_err <= ovfEv | (bus.ovf_err & ~bus.err_clr);
      bus.udf_err <= udfEv | (bus.udf_err & ~bus.err_clr);
    end
  end
  // any operand change, in any state, restarts from LOAD with fresh operands
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      opP <= '0;
      opT <= '0;
      bus.w_time <= '0;
      bus.wt_valid <= 1'b1;
    end else if (opDiff) begin
      state <= LOAD;
      opP <= pNext;
      opT <= bus.t_count;
      bus.wt_valid <= 1'b0;
    end else if (state == LOAD) begin
      state <= special ? DONE : CALC;
      bus.w_time <= special ? specialTime : bus.w_time;
      bus.wt_valid <= special;
    end else if (state == CALC && divDone) begin
      state <= DONE;
      bus.w_time <= (int'(quot) > WT_MAX) ? WT_W'(WT_MAX) : WT_W'(quot);
      bus.wt_valid <= 1'b1;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
  sbqm_wait_div #(.NUM_W(NUM_W), .TELLER_W(TELLER_W)) waitDiv (
    .clk(clk),
    .reset(reset),
    .start(divStart),
    .abort(divAbort),
    .num(num),
    .den(opT),
    .done(divDone),
    .quot(quot)
  );
`ifdef QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.peak_count <= '0;
      bus.served_count <= '0;
    end else begin
      bus.peak_count <= (pNext > bus.peak_count) ? pNext : bus.peak_count;
      bus.served_count <= bus.served_count + 16'(shrink & ~udfEv);
    end
  end
`endif
endmodule

// File: tb/tb_sbqm_queue_ctrl.sv
// tb_sbqm_queue_ctrl: directed stimulus against a cycle-level occupancy/wait-time model.
module tb_sbqm_queue_ctrl;
  localparam int DEPTH = 7;
  localparam int TELLER_W = 2;
  localparam int SVC_TIME = 3;
  localparam int WT_W = 5;
  localparam int NUM_W = $clog2(SVC_TIME * (DEPTH + 2 ** TELLER_W - 2) + 1);
  localparam int WT_MAX = 2 ** WT_W - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sbqm_queue_ctrl_if #(.DEPTH(DEPTH), .TELLER_W(TELLER_W), .WT_W(WT_W)) bus();
  sbqm_queue_ctrl #(.DEPTH(DEPTH), .TELLER_W(TELLER_W), .SVC_TIME(SVC_TIME), .WT_W(WT_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int passed = 0;
  int total = 0;
  int cyc = 0;
  bit checking = 1'b0;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic int expWait(int p, int t);
    int v;
    if (p == 0) return 0;
    if (t == 0) return WT_MAX;
    v = SVC_TIME * (p + t - 1) / t;
    return (v > WT_MAX) ? WT_MAX : v;
  endfunction

  // model: a sampled sensor fall takes effect two edges later; operand changes restart the wait estimate
  int mP, lastT, stable, lat;
  bit mOvf, mUdf, prevB, prevF, en, ex, expValid;
  int qE[$];
  int qX[$];
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset) begin
      mP = 0; mOvf = 0; mUdf = 0; prevB = 0; prevF = 0;
      qE.delete(); qX.delete();
      lastT = 0; stable = 1000;
    end else begin
      int oldP;
      oldP = mP;
      en = qE.size() > 0 && qE[0] == cyc;
      if (en) void'(qE.pop_front());
      ex = qX.size() > 0 && qX[0] == cyc;
      if (ex) void'(qX.pop_front());
      if (prevB && !bus.back_sensor) qE.push_back(cyc + 2);
      if (prevF && !bus.front_sensor) qX.push_back(cyc + 2);
      prevB = bus.back_sensor;
      prevF = bus.front_sensor;
      if (bus.err_clr) begin mOvf = 0; mUdf = 0; end
      if (en && !ex) begin
        if (mP == DEPTH) mOvf = 1; else mP++;
      end else if (ex && !en) begin
        if (mP == 0) mUdf = 1; else mP--;
      end
      if (mP != oldP || int'(bus.t_count) != lastT) stable = 0; else stable++;
      lastT = int'(bus.t_count);
    end
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      lat = (mP == 0 || lastT == 0) ? 1 : NUM_W + 2;
      expValid = stable >= lat;
      check("p_count", bus.p_count, mP);
      check("empty_flag", bus.empty_flag, int'(mP == 0));
      check("full_flag", bus.full_flag, int'(mP == DEPTH));
      check("ovf_err", bus.ovf_err, mOvf);
      check("udf_err", bus.udf_err, mUdf);
      check("wt_valid", bus.wt_valid, expValid);
      if (expValid) check("w_time", bus.w_time, expWait(mP, lastT));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit isBack);
    if (isBack) bus.back_sensor = 1'b1; else bus.front_sensor = 1'b1;
    tick(2);
    if (isBack) bus.back_sensor = 1'b0; else bus.front_sensor = 1'b0;
    tick(2);
  endtask

  initial begin
    bus.back_sensor = 1'b1;
    bus.front_sensor = 1'b1;
    bus.t_count = '0;
    bus.err_clr = 1'b0;
    tick(3);
    checking = 1'b1;
    @(negedge clk);
    check("reset_p", bus.p_count, 0);
    check("reset_empty", bus.empty_flag, 1);
    check("reset_valid", bus.wt_valid, 1);
    check("reset_wtime", bus.w_time, 0);
    reset = 1'b1;
    tick(4);
    check("held_high_p", bus.p_count, 0);
    bus.back_sensor = 1'b0;
    bus.front_sensor = 1'b0;
    tick(6);
    check("both_zero_p", bus.p_count, 0);
    check("both_zero_udf", bus.udf_err, 0);
    bus.t_count = 2;
    repeat (5) pulse(1'b1);
    tick(NUM_W + 4);
    check("five_p", bus.p_count, 5);
    check("five_wtime", bus.w_time, 9);
    check("five_valid", bus.wt_valid, 1);
    repeat (3) pulse(1'b1);
    tick(2);
    check("full_p", bus.p_count, 7);
    check("full_flag_set", bus.full_flag, 1);
    check("ovf_set", bus.ovf_err, 1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", bus.ovf_err, 0);
    check("clr_keeps_p", bus.p_count, 7);
    bus.back_sensor = 1'b1;
    bus.front_sensor = 1'b1;
    tick(2);
    bus.back_sensor = 1'b0;
    bus.front_sensor = 1'b0;
    tick(4);
    check("both_full_p", bus.p_count, 7);
    check("both_full_ovf", bus.ovf_err, 0);
    bus.t_count = 1;
    tick(NUM_W + 4);
    check("wt_t1", bus.w_time, 21);
    bus.t_count = 3;
    tick(NUM_W + 4);
    check("wt_t3", bus.w_time, 9);
    bus.t_count = 0;
    tick(3);
    check("wt_t0", bus.w_time, 31);
    bus.t_count = 1;
    tick(3);
    check("midcalc_busy", bus.wt_valid, 0);
    bus.t_count = 2;
    tick(2);
    check("restart_busy", bus.wt_valid, 0);
    tick(NUM_W + 4);
    check("restart_wtime", bus.w_time, 12);
    check("restart_valid", bus.wt_valid, 1);
    repeat (7) pulse(1'b0);
    tick(2);
    check("drained_empty", bus.empty_flag, 1);
    pulse(1'b0);
    tick(2);
    check("udf_set", bus.udf_err, 1);
    check("udf_p", bus.p_count, 0);
    repeat (4) pulse(1'b1);
    tick(3);
    @(negedge clk);
    check("pre_reset_busy", bus.wt_valid, 0);
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    check("rst_p", bus.p_count, 0);
    check("rst_wtime", bus.w_time, 0);
    check("rst_valid", bus.wt_valid, 1);
    check("rst_fsm_idle", int'(dut.state), int'(sbqm_pkg::IDLE));
    reset = 1'b1;
    tick(4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sbqm_queue_ctrl.md
Name: sbqm_queue_ctrl

Overview:
Parametrised, fully synchronous successor to the single-bank queue manager. Counts customers with back (entry) and front (exit) beam sensors, raises empty and full flags, and computes the estimated wait time arithmetically from the live teller count, with no ROM. Sits between the raw sensor pads and the display/status logic. Depth, teller-count width and service time are parameters.

Parameters:
DEPTH, 7, maximum queue occupancy (>=1)
TELLER_W, 2, width of t_count; up to 2^TELLER_W-1 tellers
SVC_TIME, 3, service time units per customer per teller
WT_W, 5, width of w_time output
CNT_W, $clog2(DEPTH+1), occupancy width (derived; do not override)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset
back_sensor  in  1  async entry beam; high = person in beam
front_sensor  in  1  async exit beam; high = person in beam
t_count  in  TELLER_W  active tellers; quasi-static, sampled each clk
err_clr  in  1  single-cycle pulse; clears sticky error flags
p_count  out  CNT_W  current occupancy
empty_flag  out  1  p_count==0
full_flag  out  1  p_count==DEPTH
w_time  out  WT_W  estimated wait, valid when wt_valid=1
wt_valid  out  1  w_time matches current p_count/t_count
ovf_err  out  1  sticky: entry seen while full
udf_err  out  1  sticky: exit seen while empty

Behaviour:
- Reset (reset=0 at posedge): p_count=0, empty_flag=1, full_flag=0, w_time=0, wt_valid=1, ovf_err=0, udf_err=0; sync flops and edge registers=0; divider aborted to IDLE.
- Sensors: 2-flop synchroniser each, then falling-edge detect (1→0 = person has passed). Event pulse is 1 cycle. p_count updates on the 3rd posedge after the input falls.
- Entry only: p_count<DEPTH → +1; p_count==DEPTH → hold, set ovf_err.
- Exit only: p_count>0 → -1; p_count==0 → hold, set udf_err.
- Both in the same cycle: p_count unchanged, no error, at any occupancy including 0 and DEPTH.
- empty_flag/full_flag: registered, updated in the same cycle as p_count, never both 1.
- err_clr clears both errors; an error event in the same cycle wins (flag stays set).
- Wait time: if p_count==0, w_time=0. If t_count==0 and p_count>0, w_time=all ones ("no service"). Otherwise w_time=floor(SVC_TIME*(p_count+t_count-1)/t_count), saturated to 2^WT_W-1.
- Divider FSM: IDLE, LOAD, CALC, DONE. When latched operands differ from the current {p_count,t_count}: wt_valid←0, LOAD latches operands and numerator (width NUM_W, sized for SVC_TIME*(DEPTH+2^TELLER_W-2)), CALC runs restoring division 1 quotient bit/cycle for NUM_W cycles, DONE writes w_time and sets wt_valid=1, then IDLE. Latency from operand change to wt_valid=1 is NUM_W+2 cycles. The two special cases skip CALC (LOAD→DONE).
- Operand change during LOAD/CALC: abort and restart from LOAD. w_time holds its stale value with wt_valid=0 until done.

Optional Feature:
QUEUE_STATS_EN: when defined, adds outputs peak_count [CNT_W] (maximum p_count since reset) and served_count [16] (successful exits, wraps at 2^16). Both reset to 0. When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package sbqm_pkg: divider state enum (IDLE/LOAD/CALC/DONE), NUM_W computation function, W_TIME_INF constant (all ones).
- One sub-module, sbqm_wait_div: unsigned iterative restoring divider with start/abort/done, parametrised on NUM_W/TELLER_W.
- Synchroniser and edge detect stay inline.

Test Plan:
- Reset with both sensors high, then release → p_count=0, empty_flag=1, no counts until a sensor falls.
- Pulse back_sensor 5 times with t_count=2 → p_count=5 three cycles after the last fall; w_time=9, wt_valid=1 after NUM_W+2 cycles.
- 8 entries, DEPTH=7 → p_count=7, full_flag=1, ovf_err=1; err_clr → ovf_err=0, p_count stays 7.
- Exit pulse at p_count=0 → udf_err=1, p_count=0. Simultaneous entry and exit falls at p_count=7 → p_count=7, no error.
- p_count=7 with t_count 1→3→0 → w_time 21, then 9, then 31. Change t_count mid-CALC → wt_valid stays 0 and the final result matches the new operands.
- Drive reset low mid-CALC at p_count=4 → next cycle p_count=0, w_time=0, wt_valid=1, FSM IDLE.
